// File: rtl/stepper_step_gen_if.sv
// Signal bundle between the register file and the step/direction generator.
// The register-file side drives the run/direction/period/zero requests
// (master); the generator drives the motor pins and the position readback
// (slave).
interface stepper_step_gen_if #(
   parameter int PERIOD_W = 18
);
   logic                motor_on;
   logic                motor_dir;
   logic [PERIOD_W-1:0] period;
   logic                zero_pos;
   logic                step;
   logic                dir_out;
   logic                en_out;
   logic                moving;
   logic signed [31:0]  position;

   modport master (
      output motor_on, motor_dir, period, zero_pos,
      input  step, dir_out, en_out, moving, position
   );

   modport slave (
      input  motor_on, motor_dir, period, zero_pos,
      output step, dir_out, en_out, moving, position
   );
endinterface

// File: rtl/stepper_step_gen.sv
// Step/direction pulse generator for the stepper motor header.
// IDLE -> SETUP (DIR settles) -> HIGH (STEP pulse) -> LOW (rest of period),
// then HIGH again, SETUP on a direction change, or IDLE when the run request
// is gone. All pins and the signed step position are registered.
module stepper_step_gen #(
   parameter int PERIOD_W     = 18,
   parameter int PULSE_CYCLES = 4,
   parameter int DIR_SETUP    = 8
) (
   input logic                clock,
   input logic                reset,
   stepper_step_gen_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      HIGH  = 2'd2,
      LOW   = 2'd3
   } state_t;

   localparam logic [PERIOD_W-1:0] SETUP_LAST = PERIOD_W'(DIR_SETUP - 1);
   localparam logic [PERIOD_W-1:0] PULSE_LAST = PERIOD_W'(PULSE_CYCLES - 1);
   localparam logic [PERIOD_W-1:0] PULSE_P1   = PERIOD_W'(PULSE_CYCLES + 1);
   localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(2 * PULSE_CYCLES);

   state_t                state_q, state_d;
   logic [PERIOD_W-1:0]   cnt_q, cnt_d;
   logic [PERIOD_W-1:0]   per_q, per_d;
   logic                  step_q, step_d;
   logic                  dir_q, dir_d;
   logic                  en_q, en_d;
   logic signed [31:0]    pos_q, pos_d;
   logic [PERIOD_W-1:0]   low_last;

   // A period shorter than one high plus one equally long low phase is
   // clamped up so the STEP low time never drops below the pulse width.
   function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] req);
      eff_period = (req < MIN_PERIOD) ? MIN_PERIOD : req;
   endfunction

   // Position moves by one step in the latched direction, wrapping mod 2^32.
   function automatic logic signed [31:0] step_pos(input logic signed [31:0] pos,
                                                   input logic              fwd);
      step_pos = fwd ? (pos + 32'sd1) : (pos - 32'sd1);
   endfunction

   // Last LOW count: the latched period minus the high time, minus one.
   // The latched period is never below 2*PULSE_CYCLES, so this cannot underflow.
   assign low_last = per_q - PULSE_P1;

   // Next-state, counter, pin and position logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      per_d   = per_q;
      step_d  = step_q;
      dir_d   = dir_q;
      en_d    = en_q;
      pos_d   = pos_q;

      case (state_q)
         IDLE: begin
            step_d = 1'b0;
            en_d   = 1'b0;
            cnt_d  = '0;
            if (bus.motor_on) begin
               state_d = SETUP;
               dir_d   = bus.motor_dir;
               en_d    = 1'b1;
            end
         end

         SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               state_d = HIGH;
               cnt_d   = '0;
               step_d  = 1'b1;
               per_d   = eff_period(bus.period);
               pos_d   = step_pos(pos_q, dir_q);
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         HIGH: begin
            if (cnt_q == PULSE_LAST) begin
               state_d = LOW;
               cnt_d   = '0;
               step_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         LOW: begin
            if (cnt_q == low_last) begin
               cnt_d = '0;
               if (!bus.motor_on) begin
                  state_d = IDLE;
                  en_d    = 1'b0;
               end else if (bus.motor_dir != dir_q) begin
                  state_d = SETUP;
                  dir_d   = bus.motor_dir;
               end else begin
                  state_d = HIGH;
                  step_d  = 1'b1;
                  per_d   = eff_period(bus.period);
                  pos_d   = step_pos(pos_q, dir_q);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            step_d  = 1'b0;
            en_d    = 1'b0;
            cnt_d   = '0;
         end
      endcase

      // Software zeroing overrides a coincident step; the pulse still goes out.
      if (bus.zero_pos) begin
         pos_d = '0;
      end
   end

   // State register and registered outputs with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         per_q   <= MIN_PERIOD;
         step_q  <= 1'b0;
         dir_q   <= 1'b0;
         en_q    <= 1'b0;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         per_q   <= per_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         en_q    <= en_d;
         pos_q   <= pos_d;
      end
   end

   assign bus.step     = step_q;
   assign bus.dir_out  = dir_q;
   assign bus.en_out   = en_q;
   assign bus.moving   = en_q;
   assign bus.position = pos_q;

endmodule

// File: tb/tb_stepper_step_gen.sv
// Directed bench for stepper_step_gen: expected STEP rising edges (cycle,
// position, direction) are queued when stimulus is applied and checked as
// the DUT produces them.
module tb_stepper_step_gen;

   localparam int PERIOD_W = 18;

   logic clock = 1'b0;
   logic reset = 1'b1;

   stepper_step_gen_if #(.PERIOD_W(PERIOD_W)) bus ();

   stepper_step_gen #(
      .PERIOD_W    (PERIOD_W),
      .PULSE_CYCLES(4),
      .DIR_SETUP   (8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          cyc;
      logic [31:0] pos;
      logic        dir;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   logic prev_step = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One clock: sample 1 ns after the edge and score any STEP rising edge.
   task automatic tick();
      exp_t e;
      @(posedge clock);
      #1;
      cyc++;
      if (bus.step === 1'b1 && prev_step === 1'b0) begin
         if (sb.size() == 0) begin
            chk("unexpected_step_at_cycle", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("step_rise_cycle", 32'(cyc), 32'(e.cyc));
            chk("step_position", bus.position, e.pos);
            chk("step_dir", 32'(bus.dir_out), 32'(e.dir));
         end
      end
      prev_step = bus.step;
   endtask

   task automatic tick_until(input int t);
      while (cyc < t) tick();
   endtask

   int b;

   initial begin
      bus.motor_on  = 1'b0;
      bus.motor_dir = 1'b0;
      bus.period    = '0;
      bus.zero_pos  = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_step", 32'(bus.step), 32'd0);
      chk("rst_dir", 32'(bus.dir_out), 32'd0);
      chk("rst_en", 32'(bus.en_out), 32'd0);
      chk("rst_moving", 32'(bus.moving), 32'd0);
      chk("rst_position", bus.position, 32'd0);
      reset = 1'b0;
      tick();

      // Forward run at period 10, then drop motor_on one cycle after a rise
      b = cyc;
      bus.period    = 18'd10;
      bus.motor_dir = 1'b1;
      bus.motor_on  = 1'b1;
      sb.push_back('{b + 9, 32'd1, 1'b1});
      sb.push_back('{b + 19, 32'd2, 1'b1});
      tick();
      chk("t1_en_after_start", 32'(bus.en_out), 32'd1);
      chk("t1_moving_after_start", 32'(bus.moving), 32'd1);
      chk("t1_dir_after_start", 32'(bus.dir_out), 32'd1);
      chk("t1_step_in_setup", 32'(bus.step), 32'd0);
      tick_until(b + 9);
      for (int k = 0; k < 10; k++) begin
         if (k > 0) tick();
         chk("t1_step_shape", 32'(bus.step), 32'(k < 4));
      end
      tick_until(b + 20);
      bus.motor_on = 1'b0;
      tick_until(b + 28);
      chk("t1_en_before_low_end", 32'(bus.en_out), 32'd1);
      tick();
      chk("t1_en_after_low_end", 32'(bus.en_out), 32'd0);
      chk("t1_moving_after_low_end", 32'(bus.moving), 32'd0);
      tick_until(b + 50);
      chk("t1_en_stays_idle", 32'(bus.en_out), 32'd0);

      // Short period clamp, period change applied on next step, reversal
      b = cyc;
      bus.period    = 18'd3;
      bus.motor_dir = 1'b1;
      bus.motor_on  = 1'b1;
      sb.push_back('{b + 9, 32'd3, 1'b1});
      sb.push_back('{b + 17, 32'd4, 1'b1});
      sb.push_back('{b + 25, 32'd5, 1'b1});
      sb.push_back('{b + 43, 32'd4, 1'b0});
      sb.push_back('{b + 53, 32'd3, 1'b0});
      tick_until(b + 9);
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         chk("t2_clamped_shape", 32'(bus.step), 32'(k < 4));
      end
      tick_until(b + 18);
      bus.period = 18'd10;
      tick_until(b + 26);
      bus.motor_dir = 1'b0;
      tick_until(b + 34);
      chk("t2_dir_held_in_low", 32'(bus.dir_out), 32'd1);
      chk("t2_en_in_low", 32'(bus.en_out), 32'd1);
      tick();
      chk("t2_dir_on_setup", 32'(bus.dir_out), 32'd0);
      chk("t2_step_in_setup", 32'(bus.step), 32'd0);
      tick_until(b + 54);

      // Reset during HIGH
      reset = 1'b1;
      tick();
      chk("t2_rst_step", 32'(bus.step), 32'd0);
      chk("t2_rst_en", 32'(bus.en_out), 32'd0);
      chk("t2_rst_moving", 32'(bus.moving), 32'd0);
      chk("t2_rst_position", bus.position, 32'd0);
      chk("t2_rst_dir", 32'(bus.dir_out), 32'd0);
      reset = 1'b0;
      bus.motor_on = 1'b0;
      tick_until(cyc + 15);
      chk("t2_idle_after_rst", 32'(bus.en_out), 32'd0);

      // Reverse from 0, then zero_pos coincident with a step
      b = cyc;
      bus.period    = 18'd10;
      bus.motor_dir = 1'b0;
      bus.motor_on  = 1'b1;
      sb.push_back('{b + 9, 32'hFFFF_FFFF, 1'b0});
      sb.push_back('{b + 19, 32'd0, 1'b0});
      tick_until(b + 18);
      bus.zero_pos = 1'b1;
      tick();
      bus.zero_pos = 1'b0;
      chk("t3_step_with_zero", 32'(bus.step), 32'd1);
      tick();
      bus.motor_on = 1'b0;
      tick_until(b + 35);
      chk("t3_idle", 32'(bus.en_out), 32'd0);

      // Preload 0x7FFFFFFF, forward step wraps to 0x80000000
      force dut.pos_q = 32'sh7FFF_FFFF;
      tick();
      tick();
      release dut.pos_q;
      tick();
      chk("t4_preload", bus.position, 32'h7FFF_FFFF);
      b = cyc;
      bus.motor_dir = 1'b1;
      bus.motor_on  = 1'b1;
      sb.push_back('{b + 9, 32'h8000_0000, 1'b1});
      tick_until(b + 10);
      bus.motor_on = 1'b0;
      tick_until(b + 30);
      chk("t4_idle", 32'(bus.en_out), 32'd0);
      chk("t4_final_position", bus.position, 32'h8000_0000);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stepper_step_gen.md
# stepper_step_gen

Step/direction pulse generator for the stepper motor port. Sits directly downstream of the processor's memory-mapped register file: consumes the motor-enable, direction and step-period words that software writes into registers and drives the STEP/DIR/EN pins on header JA. It replaces the free-running divider tap with a programmable, glitch-free step train, enforces direction setup time, and keeps a signed step position that software can read back.

## Interface
- PERIOD_W, 18: width of the step-period input and internal cycle counter.
- PULSE_CYCLES, 4: STEP high time in clocks; must be ≥1.
- DIR_SETUP, 8: clocks DIR must be stable before a STEP rising edge; must be ≥1.
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; one clock is one clean reset.
- motor_on  in  1  run request (register 4 bit 0).
- motor_dir  in  1  requested direction, 1 = forward (register 5 bit 0).
- period  in  PERIOD_W  step period in clocks.
- zero_pos  in  1  single-cycle pulse clears position.
- step  out  1  STEP pin.
- dir_out  out  1  DIR pin.
- en_out  out  1  driver enable pin.
- moving  out  1  high whenever the FSM is not IDLE.
- position  out  32  signed step count, two's complement.

## Operation
- All outputs registered. Reset: state IDLE, step=0, dir_out=0, en_out=0, moving=0, position=0, counter=0.
- Effective period P = max(period, 2*PULSE_CYCLES), latched when entering HIGH; mid-step changes to period apply to the next step only.
- States:
  - IDLE: step=0, en_out=0. If motor_on → SETUP, latch dir_out=motor_dir.
  - SETUP: en_out=1, step=0, hold DIR_SETUP cycles → HIGH.
  - HIGH: step=1 for PULSE_CYCLES cycles → LOW.
  - LOW: step=0 for P−PULSE_CYCLES cycles. At end: motor_on and motor_dir==dir_out → HIGH; motor_on and motor_dir≠dir_out → SETUP with dir_out=motor_dir; !motor_on → IDLE.
- motor_on deassertion never truncates a pulse or period: the current step completes through LOW, then IDLE.
- dir_out changes only on entry to SETUP; never changes in HIGH or LOW.
- position updates on the cycle the FSM enters HIGH: +1 if dir_out=1, −1 otherwise; wraps mod 2^32 (0x7FFFFFFF+1 = 0x80000000, 0−1 = 0xFFFFFFFF).
- zero_pos sets position=0; if coincident with a HIGH entry, zero wins (result 0, step still issued).
- en_out=1 in SETUP/HIGH/LOW, 0 in IDLE; moving equals en_out.
- Reset mid-operation: next cycle all outputs at reset values, regardless of state.

## Timing
- motor_on sampled high at edge N (from IDLE): edge N+1 en_out=1, dir_out valid, state SETUP.
- First step rising at edge N+1+DIR_SETUP; step high for exactly PULSE_CYCLES clocks.
- Continuous running: rising-to-rising spacing exactly P clocks.
- Direction reversal: rising-to-rising spacing P+DIR_SETUP clocks.
- position reflects a step at the same edge step rises.
- motor_on dropped anywhere in a step: en_out falls at the edge after LOW completes.

## Test plan
- Defaults, period=10, motor_on rises at edge 0 → en_out=1 at edge 1, step rises edge 9, high 4 clocks, next rise edge 19; position 1,2 at those edges.
- period=3 (below 8) → steps spaced 8 clocks, 4 high / 4 low.
- Running forward period=10, flip motor_dir mid-HIGH → pulse completes, dir_out changes at end of LOW, next rise 18 clocks after previous; position then decrements.
- Drop motor_on one cycle after a step rise → that pulse and its LOW complete (10 clocks), en_out=0 next edge, no further steps.
- Preload position 0x7FFFFFFF by stepping/zeroing sequence (or force), forward step → 0x80000000; from 0 reverse step → 0xFFFFFFFF; zero_pos coincident with step → 0.
- Assert reset during HIGH → next edge step=0, en_out=0, moving=0, position=0, dir_out=0.
